// File: rtl/exec_unit.sv
// exec_unit: registered RV32I/RV64I register-register ALU with valid/ready handshakes on both sides.
// Define EXEC_UNIT_MDU_EN to add the iterative M-extension multiply/divide (MUL/DIV/DONE states).
module exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    rd_q, rd_d;
  logic               accept;

  assign shamt     = rs2[SHAMT_W-1:0];
  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign accept    = in_valid && in_ready;

  // Undecoded funct7/funct3 pairs fall through to zero.
  always_comb begin
    alu_res = '0;
    if (funct7 == 7'b0000000) begin
      case (funct3)
        3'd0:    alu_res = rs1 + rs2;
        3'd1:    alu_res = rs1 << shamt;
        3'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
        3'd3:    alu_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
        3'd4:    alu_res = rs1 ^ rs2;
        3'd5:    alu_res = rs1 >> shamt;
        3'd6:    alu_res = rs1 | rs2;
        default: alu_res = rs1 & rs2;
      endcase
    end else if (funct7 == 7'b0100000) begin
      if (funct3 == 3'd0) begin
        alu_res = rs1 - rs2;
      end else if (funct3 == 3'd5) begin
        alu_res = $unsigned($signed(rs1) >>> shamt);
      end
    end
  end

`ifdef EXEC_UNIT_MDU_EN

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                dz_q, dz_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     shreg_q, shreg_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;

  logic                is_m, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag, div_val, mdu_res;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN:0]       rem_sh;
  logic                rem_ge;

  assign is_m     = (funct7 == 7'b0000001);
  assign a_signed = funct3[2] ? !funct3[0] : (funct3 == 3'd1 || funct3 == 3'd2);
  assign b_signed = funct3[2] ? !funct3[0] : (funct3 == 3'd1);
  assign a_neg    = a_signed && rs1[XLEN-1];
  assign b_neg    = b_signed && rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;

  // shreg holds the multiplier in MUL and the dividend/quotient in DIV; divisor lives in mcand low half.
  assign rem_sh  = {rem_q, shreg_q[XLEN-1]};
  assign rem_ge  = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
  assign prod_s  = neg_q ? -acc_q : acc_q;
  assign div_val = op_q[1] ? rem_q : shreg_q;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q != IDLE);

  always_comb begin
    mdu_res = '0;
    if (!op_q[2]) begin
      mdu_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (dz_q) begin
      mdu_res = op_q[1] ? a_q : '1;
    end else begin
      mdu_res = neg_q ? -div_val : div_val;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    dz_d        = dz_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    rd_d        = rd_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_m) begin
            op_d  = funct3;
            cnt_d = '0;
            a_d   = rs1;
            dz_d  = (rs2 == '0);
            rem_d = '0;
            acc_d = '0;
            mcand_d = {{XLEN{1'b0}}, funct3[2] ? b_mag : a_mag};
            shreg_d = funct3[2] ? a_mag : b_mag;
            neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            state_d = funct3[2] ? DIV : MUL;
          end else begin
            out_valid_d = 1'b1;
            rd_d        = alu_res;
          end
        end
      end
      MUL: begin
        if (shreg_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(XLEN-1)) begin
          state_d = DONE;
        end
      end
      DIV: begin
        rem_d   = rem_ge ? XLEN'(rem_sh - {1'b0, mcand_q[XLEN-1:0]}) : rem_sh[XLEN-1:0];
        shreg_d = {shreg_q[XLEN-2:0], rem_ge};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(XLEN-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        rd_d        = mdu_res;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      a_q         <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      dz_q        <= dz_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
    end
  end

`else

  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      rd_d        = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
    end
  end

`endif

endmodule
